// File: rtl/matriz_loader.sv
// Streams two SIZE x SIZE signed 8-bit matrices (A then B) into flattened buses and holds them until released.
// Optional MATRIZ_LOADER_TRANSPOSE_B_EN: the B stream is taken column-major and stored transposed.
module matriz_loader #(
  parameter int SIZE = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic signed [7:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [8*SIZE*SIZE-1:0]    matriz_a,
  output logic [8*SIZE*SIZE-1:0]    matriz_b,
  output logic                      mats_valid,
  output logic                      load_done,
  // 'release' is a reserved word, so the consumer handshake is named release_mats
  input  logic                      release_mats
);

  localparam int NELEM = SIZE * SIZE;
  localparam int KW    = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int RW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(NELEM - 1);
  localparam logic [RW-1:0] RC_LAST = RW'(SIZE - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg, k_next;
  logic [RW-1:0]   row_reg, row_next;
  logic [RW-1:0]   col_reg, col_next;
  logic            done_reg, done_next;
  logic            xfer;
  logic            last;
  logic            wr_a, wr_b;
  logic [KW-1:0]   a_idx, b_idx;

  logic signed [7:0] a_reg [NELEM];
  logic signed [7:0] b_reg [NELEM];

  assign xfer = in_valid && in_ready;
  assign last = (k_reg == K_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= LOAD_A;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD_A:  if (xfer && last) state_next = LOAD_B;
      LOAD_B:  if (xfer && last) state_next = HOLD;
      HOLD:    if (release_mats) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready   = (state_reg != HOLD);
    mats_valid = (state_reg == HOLD);
    wr_a       = xfer && (state_reg == LOAD_A);
    wr_b       = xfer && (state_reg == LOAD_B);
    load_done  = done_reg;
  end

  // Element counter kept both linear (k) and as row/col so no divider is needed
  always_comb begin
    k_next   = k_reg;
    row_next = row_reg;
    col_next = col_reg;
    if (xfer) begin
      if (last) begin
        k_next   = '0;
        row_next = '0;
        col_next = '0;
      end else begin
        k_next = k_reg + KW'(1);
        if (col_reg == RC_LAST) begin
          col_next = '0;
          row_next = row_reg + RW'(1);
        end else begin
          col_next = col_reg + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_reg   <= '0;
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      k_reg   <= k_next;
      row_reg <= row_next;
      col_reg <= col_next;
    end
  end

  // The completion pulse is registered so it coincides with the first HOLD cycle
  assign done_next = wr_b && last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= done_next;
    end
  end

  assign a_idx = KW'(row_reg) * KW'(SIZE) + KW'(col_reg);

`ifdef MATRIZ_LOADER_TRANSPOSE_B_EN
  assign b_idx = KW'(col_reg) * KW'(SIZE) + KW'(row_reg);
`else
  assign b_idx = k_reg;
`endif

  // Per-element storage; every element has its own reset so it cannot map to RAM
  generate
    for (genvar gi = 0; gi < NELEM; gi++) begin : g_elem
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_reg[gi] <= '0;
        end else if (wr_a && (a_idx == KW'(gi))) begin
          a_reg[gi] <= in_data;
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          b_reg[gi] <= '0;
        end else if (wr_b && (b_idx == KW'(gi))) begin
          b_reg[gi] <= in_data;
        end
      end

      assign matriz_a[8*gi +: 8] = a_reg[gi];
      assign matriz_b[8*gi +: 8] = b_reg[gi];
    end
  endgenerate

endmodule
